// File: rtl/main_memory_if.sv
// Shared memory port between the I$/D$ arbiter (master) and main memory (slave).
// The granted requester holds mem_req and its payload until mem_resp.
interface main_memory_if #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int CACHE_LINE_WIDTH = 128
);
  logic                        mem_req;
  logic                        mem_write;
  logic [ADDRESS_WIDTH-1:0]    mem_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_data;
  logic                        mem_resp;
  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data;
  logic                        mem_busy;

  modport master (
    output mem_req, mem_write, mem_addr, mem_data,
    input  mem_resp, mem_resp_data, mem_busy
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_data,
    output mem_resp, mem_resp_data, mem_busy
  );
endinterface

// File: rtl/main_memory.sv
// Fixed-latency line-wide main memory behind the cache arbiter.
// One request in flight; response is a single-cycle pulse MEM_LATENCY cycles after capture.
module main_memory #(
  parameter int    ADDRESS_WIDTH    = 32,
  parameter int    CACHE_LINE_WIDTH = 128,
  parameter int    MEM_LINES        = 4096,
  parameter int    MEM_LATENCY      = 5,
  parameter string INIT_FILE        = ""
) (
  input logic          clk,
  input logic          reset,
  main_memory_if.slave bus
);
  localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                        write;
    logic [IDX_W-1:0]            idx;
    logic [CACHE_LINE_WIDTH-1:0] data;
  } req_t;

  logic [CACHE_LINE_WIDTH-1:0] mem [MEM_LINES];

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic                        cap;
  req_t                        req_q, in_req, act_req;
  logic                        enter_resp;
  logic [CACHE_LINE_WIDTH-1:0] resp_q;
  logic                        unused_addr;

  // Offset bits and bits above the index are deliberately ignored (wrap).
  assign unused_addr = ^bus.mem_addr;

  assign in_req.write = bus.mem_write;
  assign in_req.idx   = bus.mem_addr[OFF +: IDX_W];
  assign in_req.data  = bus.mem_data;

  // With MEM_LATENCY==1 RESP is entered on the capture edge, so the live
  // request is used before req_q has been loaded.
  assign act_req    = (state == IDLE) ? in_req : req_q;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          cap       = 1'b1;
          cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
          state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cap) req_q <= in_req;
  end

  // Array is never cleared; a write aborted by reset is simply not committed.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && act_req.write) mem[act_req.idx] <= act_req.data;
  end

  always_ff @(posedge clk) begin
    if (!reset)          resp_q <= '0;
    else if (enter_resp) resp_q <= act_req.write ? '0 : mem[act_req.idx];
  end

  assign bus.mem_resp      = (state == RESP);
  assign bus.mem_resp_data = (state == RESP) ? resp_q : '0;
  assign bus.mem_busy      = (state != IDLE);
endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: stimulus pushes expected responses, a
// negedge monitor pops and compares data and arrival cycle.
module tb_main_memory;
  localparam int AW = 40, W = 128, LINES = 4096, LAT = 5;

  localparam logic [W-1:0] L4   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [W-1:0] L8   = 128'h0808_0808_1111_2222_3333_4444_5555_6666;
  localparam logic [W-1:0] L7   = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
  localparam logic [W-1:0] DEAD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_memory_if #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(W)) bus ();

  main_memory #(
    .ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(W), .MEM_LINES(LINES),
    .MEM_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.mem_resp === 1'b1) begin
      if (sb.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        e = sb.pop_front();
        check("resp_data", bus.mem_resp_data, e.data);
        check("resp_cycle", W'(cyc), W'(e.cyc));
      end
    end else begin
      check("no_resp_data_zero", bus.mem_resp_data, '0);
    end
  end

  task automatic wait_resp();
    bit got = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      check("busy_in_flight", W'(bus.mem_busy), 1);
      if (bus.mem_resp === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) check("resp_timeout", 0, 1);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    check("busy_after_resp", W'(bus.mem_busy), 0);
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.mem_req   = 1'b1;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_data  = data;
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the IDLE negedge after RESP.
  task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                     input logic [W-1:0] exp);
    drive(wr, addr, data);
    @(posedge clk); #1;
    sb.push_back('{exp, cyc + LAT - 1});
    wait_resp();
    bus.mem_req = 1'b0;
    idle_gap();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 40'h40, ONES);

    // Reset held with a request pending
    repeat (3) begin
      @(negedge clk);
      check("rst_resp", W'(bus.mem_resp), 0);
      check("rst_busy", W'(bus.mem_busy), 0);
      check("rst_data", bus.mem_resp_data, '0);
    end
    bus.mem_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", W'(bus.mem_busy), 0);

    // Preload lines used later
    txn(1'b1, 40'h40, L4, '0);
    txn(1'b1, 40'h80, L8, '0);
    txn(1'b1, 40'h70, L7, '0);

    // Read latency
    txn(1'b0, 40'h40, '0, L4);

    // Write then read back through a different offset in the same line
    txn(1'b1, 40'h1230, DEAD, '0);
    txn(1'b0, 40'h123C, '0, DEAD);

    // Mid-flight payload changes must be ignored
    drive(1'b0, 40'h40, '0);
    @(posedge clk); #1;
    sb.push_back('{L4, cyc + LAT - 1});
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 40'h80, ONES);
    wait_resp();
    bus.mem_req = 1'b0;
    idle_gap();
    txn(1'b0, 40'h80, '0, L8);

    // Reset in the middle of a write: no response, no commit
    drive(1'b1, 40'h70, ONES);
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mem_req = 1'b0;
    repeat (2 * LAT) begin
      @(negedge clk);
      check("abort_no_resp", W'(bus.mem_resp), 0);
      check("abort_idle", W'(bus.mem_busy), 0);
    end
    txn(1'b0, 40'h70, '0, L7);

    // Wrapping address, request held through RESP -> back-to-back
    drive(1'b0, 40'h1_0000_0040, '0);
    @(posedge clk); #1;
    sb.push_back('{L4, cyc + LAT - 1});
    sb.push_back('{L4, cyc + 2 * LAT});
    wait_resp();
    bus.mem_addr = 40'h1_0040;
    @(negedge clk);
    check("b2b_idle_gap", W'(bus.mem_busy), 0);
    wait_resp();
    bus.mem_req = 1'b0;
    idle_gap();

    repeat (2 * LAT) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
